// File: rtl/bsg_fsb_pkg.sv
// rtl/bsg_fsb_pkg.sv - shared FSB packet width and packet type
package bsg_fsb_pkg;

    localparam int fsb_packet_width_gp = 80;

    typedef logic [fsb_packet_width_gp-1:0] fsb_packet_t;

endpackage

// File: rtl/fsb_rr_grant.sv
// rtl/fsb_rr_grant.sv - round-robin one-hot grant with last-grant pointer
module fsb_rr_grant #(
    parameter int num_req_p = 2,
    localparam int idx_width_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [num_req_p-1:0]    v_i,
    input  logic                    en_i,
    output logic [num_req_p-1:0]    grant_o,
    output logic [idx_width_lp-1:0] grant_idx_o
);

    logic [idx_width_lp-1:0] last_grant_r;
    int                      best_dist;

    // Distance of requester i from the slot just after the last grant; nearest valid one wins.
    function automatic int rr_dist(input int i, input logic [idx_width_lp-1:0] last);
        int d;
        d = i - int'(last) - 1;
        if (d < 0)
            d = d + num_req_p;
        return d;
    endfunction

    always_comb begin
        best_dist   = num_req_p;
        grant_o     = '0;
        grant_idx_o = '0;
        for (int i = 0; i < num_req_p; i++) begin
            if (v_i[i] && (rr_dist(i, last_grant_r) < best_dist))
                best_dist = rr_dist(i, last_grant_r);
        end
        for (int i = 0; i < num_req_p; i++) begin
            if (v_i[i] && (rr_dist(i, last_grant_r) == best_dist)) begin
                grant_o[i]  = 1'b1;
                grant_idx_o = i[idx_width_lp-1:0];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i)
            last_grant_r <= idx_width_lp'(num_req_p - 1);
        else if (en_i)
            last_grant_r <= grant_idx_o;
    end

endmodule

// File: rtl/fsb_tx_rr_arbiter.sv
// rtl/fsb_tx_rr_arbiter.sv - round-robin packet arbiter onto the host->FSB channel
module fsb_tx_rr_arbiter
    import bsg_fsb_pkg::*;
#(
    parameter int num_req_p    = 2,
    parameter int data_width_p = fsb_packet_width_gp,
    parameter int cnt_width_p  = 16
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic [num_req_p-1:0]              v_i,
    input  logic [num_req_p*data_width_p-1:0] data_i,
    output logic [num_req_p-1:0]              ready_o,
    output logic                              fsb_v_o,
    output logic [data_width_p-1:0]           fsb_data_o,
    input  logic                              fsb_ready_i,
    input  logic                              clear_cnt_i,
    output logic [num_req_p*cnt_width_p-1:0]  sent_cnt_o
);

    localparam int idx_width_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;

    logic                    out_v_r;
    logic [data_width_p-1:0] out_data_r;
    logic [data_width_p-1:0] sel_data;
    logic [num_req_p-1:0]    grant;
    logic [idx_width_lp-1:0] grant_idx;
    logic                    can_load;
    logic                    accept;

    // Register empties or drains this cycle; reset also blocks acceptance so no packet is lost.
    assign can_load = (~out_v_r | fsb_ready_i) & ~reset_i;
    assign accept   = can_load & (|v_i);
    assign ready_o  = grant & {num_req_p{can_load}};

    fsb_rr_grant #(
        .num_req_p(num_req_p)
    ) rr_grant (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .v_i        (v_i),
        .en_i       (accept),
        .grant_o    (grant),
        .grant_idx_o(grant_idx)
    );

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < num_req_p; i++) begin
            if (grant_idx == idx_width_lp'(i))
                sel_data = data_i[i*data_width_p +: data_width_p];
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            out_v_r    <= 1'b0;
            out_data_r <= '0;
        end else if (accept) begin
            out_v_r    <= 1'b1;
            out_data_r <= sel_data;
        end else if (fsb_ready_i) begin
            out_v_r    <= 1'b0;
        end
    end

    assign fsb_v_o    = out_v_r;
    assign fsb_data_o = out_data_r;

    for (genvar i = 0; i < num_req_p; i++) begin : g_cnt
        logic [cnt_width_p-1:0] cnt_r;

        // Clear wins over a coincident accept.
        always_ff @(posedge clk_i) begin
            if (reset_i | clear_cnt_i)
                cnt_r <= '0;
            else if (accept & grant[i])
                cnt_r <= cnt_r + cnt_width_p'(1);
        end

        assign sent_cnt_o[i*cnt_width_p +: cnt_width_p] = cnt_r;
    end

endmodule

// File: tb/tb_fsb_tx_rr_arbiter.sv
// tb/tb_fsb_tx_rr_arbiter.sv - scoreboard bench for fsb_tx_rr_arbiter
module tb_fsb_tx_rr_arbiter;

    localparam int N  = 2;
    localparam int DW = 80;
    localparam int CW = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    v;
    logic [N*DW-1:0] data;
    logic [N-1:0]    ready;
    logic            fsb_v;
    logic [DW-1:0]   fsb_data;
    logic            fsb_ready;
    logic            clear;
    logic [N*CW-1:0] sent_cnt;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] req_d [N];
    logic [N-1:0]  req_v;

    int            m_last;
    bit            m_full;
    int            m_cnt [N];
    logic [DW-1:0] exp_q [$];
    int            g_last;
    bit            model_valid;

    always #5 clk = ~clk;

    fsb_tx_rr_arbiter #(
        .num_req_p   (N),
        .data_width_p(DW),
        .cnt_width_p (CW)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .v_i        (v),
        .data_i     (data),
        .ready_o    (ready),
        .fsb_v_o    (fsb_v),
        .fsb_data_o (fsb_data),
        .fsb_ready_i(fsb_ready),
        .clear_cnt_i(clear),
        .sent_cnt_o (sent_cnt)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand80();
        return {16'($urandom), $urandom, $urandom};
    endfunction

    // One clock: drive, check at negedge against the model, then advance the model at posedge.
    task automatic step();
        int   g;
        logic can;
        v    = req_v;
        data = {req_d[1], req_d[0]};
        @(negedge clk);
        g   = -1;
        can = !m_full || fsb_ready;
        if (!reset && can) begin
            for (int k = 1; k <= N; k++) begin
                if (g < 0 && req_v[(m_last + k) % N])
                    g = (m_last + k) % N;
            end
        end
        if (model_valid) begin
            check("ready", ready, (g >= 0) ? (1 << g) : 0);
            check("fsb_v", fsb_v, m_full);
            for (int i = 0; i < N; i++)
                check("sent_cnt", sent_cnt[i*CW +: CW], m_cnt[i]);
        end
        @(posedge clk);
        if (reset) begin
            m_last = N - 1;
            m_full = 1'b0;
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
            exp_q.delete();
        end else begin
            if (g >= 0) begin
                exp_q.push_back(req_d[g]);
                m_last = g;
                m_full = 1'b1;
            end else if (fsb_ready) begin
                m_full = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (clear) m_cnt[i] = 0;
                else if (g == i) m_cnt[i] = (m_cnt[i] + 1) % (1 << CW);
            end
        end
        g_last = g;
        #1;
    endtask

    // Accepted requesters get a fresh packet; held requesters keep theirs.
    task automatic refresh(input bit keep_valid);
        for (int i = 0; i < N; i++) begin
            if (g_last == i) begin
                req_d[i] = rand80();
                if (!keep_valid) req_v[i] = ($urandom_range(0, 2) != 0);
            end else if (!req_v[i] && !keep_valid) begin
                req_v[i] = ($urandom_range(0, 2) != 0);
                req_d[i] = rand80();
            end
        end
    endtask

    always @(negedge clk) begin
        if (model_valid && !reset && fsb_v) begin
            if (exp_q.size() == 0) begin
                check("unexpected_fsb_v", fsb_v, 1'b0);
            end else begin
                check("fsb_data", fsb_data, exp_q[0]);
                if (fsb_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        reset = 1'b1; v = '0; data = '0; fsb_ready = 1'b0; clear = 1'b0;
        req_v = '0; req_d[0] = '0; req_d[1] = '0;
        model_valid = 1'b0; g_last = -1;
        m_last = N - 1; m_full = 1'b0; m_cnt[0] = 0; m_cnt[1] = 0;
        @(posedge clk); #1;
        model_valid = 1'b1;
        step();
        reset = 1'b0;
        check("reset_fsb_v", fsb_v, 1'b0);
        check("reset_cnt", sent_cnt, '0);

        fsb_ready = 1'b1;
        req_v = 2'b01; req_d[0] = 80'hA5;
        step();
        req_v = 2'b00;
        check("single_fsb_v", fsb_v, 1'b1);
        check("single_data", fsb_data, 80'hA5);
        check("single_cnt0", sent_cnt[0 +: CW], 1);
        step();

        clear = 1'b1; step(); clear = 1'b0;
        req_v = 2'b11; req_d[0] = rand80(); req_d[1] = rand80();
        for (int i = 0; i < 8; i++) begin step(); refresh(1'b1); end
        check("rot_cnt0", sent_cnt[0 +: CW], 4);
        check("rot_cnt1", sent_cnt[CW +: CW], 4);

        fsb_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin step(); refresh(1'b1); end
        fsb_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin step(); refresh(1'b1); end

        clear = 1'b1; req_v = 2'b00; step(); clear = 1'b0;
        req_v = 2'b10;
        for (int i = 0; i < 16; i++) begin step(); refresh(1'b1); end
        check("wrap_cnt1", sent_cnt[CW +: CW], 0);
        req_v = 2'b01; clear = 1'b1;
        step(); refresh(1'b1);
        clear = 1'b0;
        check("clear_vs_accept", sent_cnt[0 +: CW], 0);

        req_v = 2'b11; step(); refresh(1'b1);
        fsb_ready = 1'b0; step(); refresh(1'b1);
        check("pre_reset_full", fsb_v, 1'b1);
        reset = 1'b1; step(); reset = 1'b0;
        check("reset_drop", fsb_v, 1'b0);
        fsb_ready = 1'b1; req_v = 2'b11;
        step(); refresh(1'b1);
        check("reset_first_r0", g_last, 0);

        for (int i = 0; i < 400; i++) begin
            fsb_ready = ($urandom_range(0, 3) != 0);
            clear     = ($urandom_range(0, 49) == 0);
            reset     = ($urandom_range(0, 199) == 0);
            step();
            refresh(1'b0);
        end
        reset = 1'b0; clear = 1'b0; fsb_ready = 1'b1; req_v = '0;
        for (int i = 0; i < 3; i++) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
